acker_pwm_bank: RTL and testbench
=================================

# acker_pwm_bank

Multi-channel, parametrised PWM generator for the Ackerchip actuator outputs. It is the successor to the single-channel PWM block and drives `CHANNELS` outputs from one shared period counter. Each channel has its own double-buffered duty value, which changes only at a period boundary and optionally ramps toward its target by one step per period. The block sits between the control logic, which writes duty values, and the external analog filters and drivers.

## Interface
Parameters:
- `WIDTH`, 8: duty and counter width. The period is 2^WIDTH−1 ticks.
- `CHANNELS`, 4: number of PWM outputs, from 1 to 16.
- `CH_BITS`, 2: channel index width. Must satisfy 2^CH_BITS ≥ CHANNELS.

Ports:
- `clock`  in  1: rising-edge clock.
- `reset`  in  1: synchronous, active-low reset.
- `power`  in  1: global run enable.
- `prescale`  in  8: the counter advances once every `prescale`+1 clocks.
- `write`  in  1: one-cycle write strobe.
- `channel`  in  CH_BITS: target channel of the write.
- `voltage`  in  WIDTH: new target duty.
- `slew`  in  1: ramp mode for this write. 1 = ramp, 0 = jump.
- `writeAck`  out  1: pulses high for one cycle after a write is accepted.
- `periodStart`  out  1: pulses high for one cycle at the start of each period.
- `settled`  out  CHANNELS: bit i is high when active[i] equals target[i].
- `analogOutput`  out  CHANNELS: the PWM outputs.

## Operation
- **Prescaler.** `pre` counts from 0 to `prescale`. `tick` = (`pre` == `prescale`). On a tick, `pre` returns to 0.
- **Period counter.** `cnt` advances by 1 on each tick and runs from 0 to PMAX = 2^WIDTH−2. A boundary occurs when `tick` is high and `cnt` == PMAX; at a boundary, `cnt` returns to 0.
- **Per-channel state.** Each channel holds `target[i]`, `active[i]` (both WIDTH bits) and a `mode[i]` bit.
- **Writes.**
  - A write is accepted when `write` is high and `channel` < CHANNELS. It loads `target[channel]` and `mode[channel]` (the value of `slew`) at that edge.
  - Writes are accepted regardless of `power`.
  - A write with `channel` ≥ CHANNELS is ignored and produces no `writeAck`.
  - A later write to the same channel overwrites a pending target.
- **Boundary update, per channel.**
  - Jump mode: `active` takes the value of `target`.
  - Ramp mode: `active` moves one step toward `target`, either +1 or −1. If they are already equal, it holds.
  - A write and a boundary on the same edge: the boundary uses the old target. The new target takes effect at the next boundary.
- **Output.** `analogOutput[i]` is a register loaded each clock with `power` & (`cnt` < `active[i]`), using the pre-edge register values.
  - Duty 0 gives a constant low output.
  - Duty 2^WIDTH−1 gives a constant high output.
  - Duty d gives d high ticks per period.
- **Power.**
  - While `power` = 0: `pre` and `cnt` are held at 0, `analogOutput` is 0, and no boundaries occur.
  - `target`, `active` and `mode` are retained while power is off.
  - When `power` rises, counting restarts from `cnt` = 0.
- **`settled[i]`.** Combinational: (`active[i]` == `target[i]`).

## Timing
- **Reset values.** While `reset` is low at an edge, every register clears: `pre`, `cnt`, `target`, `active` and `mode` are 0, and `writeAck`, `periodStart` and `analogOutput` are 0. `settled` is all ones. A reset in the middle of a period or a ramp aborts it immediately.
- **Write latency.** `writeAck` is high in the cycle following the accepting edge. Back-to-back writes on consecutive cycles are all accepted.
- **`periodStart`.** Registered. High in the first cycle in which `cnt` = 0 after a boundary. Also high in the first cycle after `power` rises or after reset is released while `power` = 1.
- **Output lag.** `analogOutput` lags the counter by one clock.
- **Period length.** A period lasts (2^WIDTH−1)·(`prescale`+1) clocks.
- **Duty change latency.** A new duty first appears in the output in the period following the first boundary after the write.
- **Ramp duration.** A ramp over a distance of k steps completes after k boundaries. `settled` rises in the cycle after the k-th boundary edge.
- **Prescale changes.** A change to `prescale` takes effect immediately. If `pre` is greater than the new `prescale`, `pre` keeps counting and wraps modulo 256 before ticking.

## Test plan
All scenarios use `WIDTH`=8, `CHANNELS`=4 and `prescale`=0 unless stated otherwise.
- **Reset.** Hold `reset` low for 3 clocks with `power`=1 and `write` pulses applied. Required: all outputs 0, `writeAck` 0, `settled`=4'b1111.
- **Jump write.** Write ch1=64 with `slew`=0. Required: `writeAck` high for 1 cycle. From the next period, `analogOutput[1]` is high for exactly 64 of every 255 clocks. The other outputs stay low.
- **Extremes.** Write ch0=255 and ch3=0. Required: after the boundary, ch0 is constantly high and ch3 is constantly low. A write to `channel`=5 is not possible here because the index is 2 bits wide. A separate bench with `CHANNELS`=3 writes to ch3 and requires no ack and no state change.
- **Ramp.** Write ch2=3 with `slew`=1. Required: `active[2]` is 1, 2 and 3 after successive boundaries. `settled[2]` rises after the third boundary. A subsequent ramp write back to 0 steps down through 2, 1, 0.
- **Write on the boundary edge.** Write ch1=100 on the same edge as a boundary. Required: the following period still uses the old duty, and 100 appears one period later.
- **Prescale and power.** Set `prescale`=3. Required: the `periodStart` spacing is 1020 clocks. Drop `power` mid-period: all outputs are 0 within 1 clock, and the duty values are retained. Raise `power` again: `periodStart` pulses once and the previous duties resume.

Source files
------------

// File: rtl/acker_pwm_bank_if.sv
// rtl/acker_pwm_bank_if.sv - duty-write bus for the acker_pwm_bank PWM generator
//
// Carries one duty write per cycle from the control logic into the PWM bank.
//   write    : one-cycle write strobe (master -> slave)
//   channel  : target channel index, CH_BITS wide (master -> slave)
//   voltage  : new target duty, WIDTH wide (master -> slave)
//   slew     : 1 = ramp toward the target, 0 = jump at the next boundary (master -> slave)
//   writeAck : one-cycle pulse in the cycle after an accepted write (slave -> master)

interface acker_pwm_bank_if #(
    parameter int WIDTH   = 8,
    parameter int CH_BITS = 2
);
    logic               write;
    logic [CH_BITS-1:0] channel;
    logic [WIDTH-1:0]   voltage;
    logic               slew;
    logic               writeAck;

    modport master (
        output write,
        output channel,
        output voltage,
        output slew,
        input  writeAck
    );

    modport slave (
        input  write,
        input  channel,
        input  voltage,
        input  slew,
        output writeAck
    );
endinterface

// File: rtl/acker_pwm_bank.sv
// rtl/acker_pwm_bank.sv - multi-channel PWM bank with shared period counter and double-buffered duties
//
// Drives CHANNELS PWM outputs from one prescaled period counter of 2^WIDTH-1 ticks.
// Every channel keeps a target duty (written over the bus) and an active duty
// (used for comparison). The active duty changes only at a period boundary,
// either jumping to the target or stepping one count toward it.
//
// Ports:
//   clock        : rising-edge clock
//   reset        : synchronous, active-low reset
//   power        : global run enable; when low the counters are held and outputs forced low
//   prescale     : counter advances once every prescale+1 clocks
//   bus          : duty write bus (write/channel/voltage/slew in, writeAck out)
//   periodStart  : one-cycle pulse at the start of each period and on power-up
//   settled      : per channel, active duty equals target duty
//   analogOutput : registered PWM outputs, one clock behind the counter

module acker_pwm_bank #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CH_BITS  = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                power,
    input  logic [7:0]          prescale,
    acker_pwm_bank_if.slave     bus,
    output logic                periodStart,
    output logic [CHANNELS-1:0] settled,
    output logic [CHANNELS-1:0] analogOutput
);

    // Last counter value of a period; the period is PMAX+1 = 2^WIDTH-1 ticks,
    // so a duty of 2^WIDTH-1 is above every counter value and stays high.
    localparam logic [WIDTH-1:0]   PMAX     = {{(WIDTH-1){1'b1}}, 1'b0};
    localparam logic [CH_BITS:0]   CH_LIMIT = (CH_BITS+1)'(CHANNELS);

    logic [7:0]       pre;
    logic [WIDTH-1:0] cnt;
    logic             power_q;
    logic             write_ack;

    logic [WIDTH-1:0] target [CHANNELS];
    logic [WIDTH-1:0] active [CHANNELS];
    logic             mode   [CHANNELS];

    logic             tick;
    logic             boundary;
    logic             write_ok;

    // pre wraps modulo 256 on its own, so a prescale lowered below the current
    // pre value simply waits for the wrap before the next tick.
    assign tick     = power && (pre == prescale);
    assign boundary = tick && (cnt == PMAX);
    assign write_ok = bus.write && ({1'b0, bus.channel} < CH_LIMIT);

    assign bus.writeAck = write_ack;

    always_comb begin
        settled = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            settled[i] = (active[i] == target[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pre          <= '0;
            cnt          <= '0;
            power_q      <= 1'b0;
            write_ack    <= 1'b0;
            periodStart  <= 1'b0;
            analogOutput <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                target[i] <= '0;
                active[i] <= '0;
                mode[i]   <= 1'b0;
            end
        end else begin
            power_q   <= power;
            write_ack <= write_ok;

            // A clear power_q marks the first powered edge, which also covers
            // the first edge after reset release with power already high.
            periodStart <= power && (boundary || !power_q);

            if (!power) begin
                pre <= '0;
                cnt <= '0;
            end else if (tick) begin
                pre <= '0;
                cnt <= boundary ? '0 : cnt + 1'b1;
            end else begin
                pre <= pre + 1'b1;
            end

            for (int i = 0; i < CHANNELS; i++) begin
                analogOutput[i] <= power && (cnt < active[i]);

                // The boundary reads the pre-edge target and mode, so a write
                // landing on the boundary edge waits for the next boundary.
                if (boundary) begin
                    if (mode[i]) begin
                        if (active[i] < target[i]) begin
                            active[i] <= active[i] + 1'b1;
                        end else if (active[i] > target[i]) begin
                            active[i] <= active[i] - 1'b1;
                        end
                    end else begin
                        active[i] <= target[i];
                    end
                end

                if (write_ok && (bus.channel == CH_BITS'(i))) begin
                    target[i] <= bus.voltage;
                    mode[i]   <= bus.slew;
                end
            end
        end
    end

endmodule

// File: tb/tb_acker_pwm_bank.sv
// tb/tb_acker_pwm_bank.sv - scoreboard bench for acker_pwm_bank

module tb_acker_pwm_bank;

    logic       clock = 1'b0;
    logic       reset;
    logic       power;
    logic [7:0] prescale;
    logic       periodStart;
    logic [3:0] settled;
    logic [3:0] analogOutput;

    logic       power2;
    logic [7:0] prescale2;
    logic       periodStart2;
    logic [2:0] settled2;
    logic [2:0] analogOutput2;

    acker_pwm_bank_if #(.WIDTH(8), .CH_BITS(2)) bus1 ();
    acker_pwm_bank_if #(.WIDTH(8), .CH_BITS(2)) bus2 ();

    acker_pwm_bank #(.WIDTH(8), .CHANNELS(4), .CH_BITS(2)) dut (
        .clock        (clock),
        .reset        (reset),
        .power        (power),
        .prescale     (prescale),
        .bus          (bus1),
        .periodStart  (periodStart),
        .settled      (settled),
        .analogOutput (analogOutput)
    );

    acker_pwm_bank #(.WIDTH(8), .CHANNELS(3), .CH_BITS(2)) dut3 (
        .clock        (clock),
        .reset        (reset),
        .power        (power2),
        .prescale     (prescale2),
        .bus          (bus2),
        .periodStart  (periodStart2),
        .settled      (settled2),
        .analogOutput (analogOutput2)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One expected period: high-cycle count per channel and period length in clocks.
    typedef struct packed {
        logic [3:0][15:0] hi;
        logic [15:0]      len;
    } period_t;

    period_t exp_q [$];
    logic    mon_en = 1'b0;
    logic    in_period = 1'b0;
    int      hi_cnt [4];
    int      len_cnt;

    task automatic push(input int h0, input int h1, input int h2, input int h3, input int len);
        period_t e;
        e.hi[0] = 16'(h0);
        e.hi[1] = 16'(h1);
        e.hi[2] = 16'(h2);
        e.hi[3] = 16'(h3);
        e.len   = 16'(len);
        exp_q.push_back(e);
    endtask

    // Output lags the counter by one clock, so a period's outputs occupy the
    // cycles after one periodStart up to and including the next periodStart.
    task automatic monitor();
        period_t e;
        if (!mon_en) begin
            in_period = 1'b0;
        end else begin
            if (in_period) begin
                for (int c = 0; c < 4; c++) hi_cnt[c] += int'(analogOutput[c]);
                len_cnt++;
            end
            if (periodStart) begin
                if (in_period && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("period_len", len_cnt, 32'(e.len));
                    for (int c = 0; c < 4; c++) begin
                        check($sformatf("duty_ch%0d", c), hi_cnt[c], 32'(e.hi[c]));
                    end
                end
                in_period = 1'b1;
                for (int c = 0; c < 4; c++) hi_cnt[c] = 0;
                len_cnt = 0;
            end
        end
    endtask

    always @(negedge clock) monitor();

    task automatic arm();
        @(posedge clock);
        #1;
        mon_en = 1'b1;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clock);
            n++;
        end
        check("sb_drained", exp_q.size(), 0);
        exp_q.delete();
        @(posedge clock);
        #1;
        mon_en = 1'b0;
    endtask

    task automatic wait_ps(input int limit);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!periodStart && n < limit);
        check("ps_seen", periodStart, 1);
    endtask

    // Called at a negedge; returns two negedges later.
    task automatic do_write(input logic [1:0] ch, input logic [7:0] v, input logic s);
        bus1.write   = 1'b1;
        bus1.channel = ch;
        bus1.voltage = v;
        bus1.slew    = s;
        @(negedge clock);
        bus1.write = 1'b0;
        check("ack_hi", bus1.writeAck, 1);
        @(negedge clock);
        check("ack_lo", bus1.writeAck, 0);
    endtask

    int pulses;
    logic [3:0] hi_seen;

    initial begin
        reset        = 1'b0;
        power        = 1'b1;
        prescale     = 8'd0;
        bus1.write   = 1'b0;
        bus1.channel = '0;
        bus1.voltage = '0;
        bus1.slew    = 1'b0;
        power2       = 1'b0;
        prescale2    = 8'd0;
        bus2.write   = 1'b0;
        bus2.channel = '0;
        bus2.voltage = '0;
        bus2.slew    = 1'b0;

        // Reset held for 3 clocks while writes are pulsed
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("rst_out", analogOutput, 0);
            check("rst_ack", bus1.writeAck, 0);
            check("rst_ps", periodStart, 0);
            check("rst_settled", settled, 4'hF);
            bus1.write   = 1'b1;
            bus1.channel = 2'd1;
            bus1.voltage = 8'd9;
        end
        @(negedge clock);
        check("rst_ack_end", bus1.writeAck, 0);
        reset      = 1'b1;
        bus1.write = 1'b0;
        @(negedge clock);
        check("ps_after_reset", periodStart, 1);
        check("settled_after_reset", settled, 4'hF);

        // Three-channel instance: ch2 accepted with power off, ch3 ignored
        bus2.write   = 1'b1;
        bus2.channel = 2'd2;
        bus2.voltage = 8'd5;
        @(negedge clock);
        bus2.channel = 2'd3;
        bus2.voltage = 8'd7;
        check("c3_ack_ch2", bus2.writeAck, 1);
        check("c3_settled_ch2", settled2, 3'b011);
        @(negedge clock);
        bus2.write = 1'b0;
        check("c3_ack_ch3", bus2.writeAck, 0);
        check("c3_settled_ch3", settled2, 3'b011);
        check("c3_out", analogOutput2, 0);

        // Jump write ch1=64
        wait_ps(300);
        do_write(2'd1, 8'd64, 1'b0);
        check("jump_pending", settled[1], 0);
        wait_ps(300);
        arm();
        push(0, 64, 0, 0, 255);
        push(0, 64, 0, 0, 255);
        drain(1000);

        // Extremes, back-to-back writes ch0=255 and ch3=0
        @(negedge clock);
        bus1.write   = 1'b1;
        bus1.channel = 2'd0;
        bus1.voltage = 8'd255;
        bus1.slew    = 1'b0;
        @(negedge clock);
        check("b2b_ack0", bus1.writeAck, 1);
        bus1.channel = 2'd3;
        bus1.voltage = 8'd0;
        @(negedge clock);
        check("b2b_ack1", bus1.writeAck, 1);
        bus1.write = 1'b0;
        @(negedge clock);
        check("b2b_ack_lo", bus1.writeAck, 0);
        wait_ps(300);
        arm();
        push(255, 64, 0, 0, 255);
        push(255, 64, 0, 0, 255);
        drain(1000);

        // Ramp ch2 up to 3, then back down to 0
        wait_ps(300);
        do_write(2'd2, 8'd3, 1'b1);
        check("ramp_up_unsettled", settled[2], 0);
        arm();
        push(255, 64, 1, 0, 255);
        push(255, 64, 2, 0, 255);
        push(255, 64, 3, 0, 255);
        drain(1500);
        check("ramp_up_settled", settled[2], 1);

        wait_ps(300);
        do_write(2'd2, 8'd0, 1'b1);
        check("ramp_dn_unsettled", settled[2], 0);
        arm();
        push(255, 64, 2, 0, 255);
        push(255, 64, 1, 0, 255);
        push(255, 64, 0, 0, 255);
        drain(1500);
        check("ramp_dn_settled", settled[2], 1);

        // Write ch1=100 on the boundary edge
        wait_ps(300);
        push(255, 64, 0, 0, 255);
        push(255, 100, 0, 0, 255);
        arm();
        repeat (254) @(negedge clock);
        bus1.write   = 1'b1;
        bus1.channel = 2'd1;
        bus1.voltage = 8'd100;
        bus1.slew    = 1'b0;
        @(negedge clock);
        bus1.write = 1'b0;
        check("bnd_is_boundary", periodStart, 1);
        check("bnd_ack", bus1.writeAck, 1);
        check("bnd_old_duty", settled[1], 0);
        drain(1000);
        check("bnd_settled", settled[1], 1);

        // Prescale 3
        @(negedge clock);
        prescale = 8'd3;
        wait_ps(1100);
        arm();
        push(1020, 400, 0, 0, 1020);
        push(1020, 400, 0, 0, 1020);
        drain(3500);

        // Power drop mid-period and recovery
        wait_ps(1100);
        repeat (100) @(negedge clock);
        check("pre_drop_ch0", analogOutput[0], 1);
        power = 1'b0;
        @(negedge clock);
        check("drop_out", analogOutput, 0);
        pulses  = 0;
        hi_seen = '0;
        repeat (1100) begin
            @(negedge clock);
            pulses  += int'(periodStart);
            hi_seen |= analogOutput;
        end
        check("off_no_ps", pulses, 0);
        check("off_out", hi_seen, 0);
        check("off_settled", settled, 4'hF);
        power = 1'b1;
        @(negedge clock);
        check("ps_power_up", periodStart, 1);
        pulses = int'(periodStart);
        repeat (29) begin
            @(negedge clock);
            pulses += int'(periodStart);
        end
        check("power_up_pulses", pulses, 1);
        wait_ps(1100);
        arm();
        push(1020, 400, 0, 0, 1020);
        drain(2500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
